// File: rtl/change_dispenser.sv
// change_dispenser: payout controller for a 10-unit and a 5-unit coin hopper.
// Pays largest coin first, handshakes each coin with coin_sense, keeps the
// on-board coin inventory and reports the unpaid shortfall of each payout.
// Optional macro CHANGE_AUDIT_EN adds a 16-bit paid_total output that counts
// every value unit actually dispensed (wraps modulo 2^16).
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for a request, req_ready high
// S_SEL   | one cycle: choose the next coin or finish
// S_EJECT | selected hopper driven, waiting for coin_sense or timeout
// S_GAP   | hopper recovery, ejects low for GAP_CYC cycles
// S_DONE  | one cycle: done pulse, shortfall published
module change_dispenser #(
    parameter int AMT_W   = 8,
    parameter int CNT_W   = 6,
    parameter int TIMEOUT = 16,
    parameter int GAP_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             load_10,
    input  logic             load_5,
    input  logic             coin_sense,
    output logic             eject_10,
    output logic             eject_5,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remaining,
    output logic [CNT_W-1:0] inv_10,
`ifdef CHANGE_AUDIT_EN
    output logic [CNT_W-1:0] inv_5,
    output logic [15:0]      paid_total
`else
    output logic [CNT_W-1:0] inv_5
`endif
);

    localparam int TMR_MAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [AMT_W-1:0] TEN  = AMT_W'(10);
    localparam logic [AMT_W-1:0] FIVE = AMT_W'(5);
    localparam logic [CNT_W-1:0] INV_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_EJECT,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [AMT_W-1:0] rem_q;
    logic [TMR_W-1:0] tmr_q;
    logic             coin_10_q;
    logic             eject_10_q, eject_5_q, done_q, short_q;
    logic [AMT_W-1:0] remaining_q;
    logic [CNT_W-1:0] inv_10_q, inv_10_d, inv_5_q, inv_5_d;

    logic             in_eject, sensed, timed_out;
    logic [AMT_W-1:0] coin_val;

    assign in_eject  = (state_q == S_EJECT);
    assign sensed    = in_eject && coin_sense;
    assign timed_out = in_eject && !coin_sense && (tmr_q == '0);
    assign coin_val  = coin_10_q ? TEN : FIVE;

    assign req_ready = (state_q == S_IDLE);
    assign eject_10  = eject_10_q;
    assign eject_5   = eject_5_q;
    assign done      = done_q;
    assign short     = short_q;
    assign remaining = remaining_q;
    assign inv_10    = inv_10_q;
    assign inv_5     = inv_5_q;

    // Inventory next-state: jam clear beats load, load and dispense cancel, loads saturate.
    always_comb begin
        inv_10_d = inv_10_q;
        inv_5_d  = inv_5_q;
        if (timed_out && coin_10_q) begin
            inv_10_d = '0;
        end else if (sensed && coin_10_q) begin
            if (!load_10) inv_10_d = inv_10_q - 1'b1;
        end else if (load_10 && inv_10_q != INV_MAX) begin
            inv_10_d = inv_10_q + 1'b1;
        end
        if (timed_out && !coin_10_q) begin
            inv_5_d = '0;
        end else if (sensed && !coin_10_q) begin
            if (!load_5) inv_5_d = inv_5_q - 1'b1;
        end else if (load_5 && inv_5_q != INV_MAX) begin
            inv_5_d = inv_5_q + 1'b1;
        end
    end

    // Inventory registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv_10_q <= '0;
            inv_5_q  <= '0;
        end else begin
            inv_10_q <= inv_10_d;
            inv_5_q  <= inv_5_d;
        end
    end

    // Payout sequencer with registered eject/done/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            tmr_q       <= '0;
            coin_10_q   <= 1'b0;
            eject_10_q  <= 1'b0;
            eject_5_q   <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            remaining_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        rem_q       <= req_amount;
                        short_q     <= 1'b0;
                        remaining_q <= '0;
                        state_q     <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (rem_q >= TEN && inv_10_q != '0) begin
                        coin_10_q  <= 1'b1;
                        eject_10_q <= 1'b1;
                        tmr_q      <= TMR_W'(TIMEOUT - 1);
                        state_q    <= S_EJECT;
                    end else if (rem_q >= FIVE && inv_5_q != '0) begin
                        coin_10_q  <= 1'b0;
                        eject_5_q  <= 1'b1;
                        tmr_q      <= TMR_W'(TIMEOUT - 1);
                        state_q    <= S_EJECT;
                    end else begin
                        done_q      <= 1'b1;
                        remaining_q <= rem_q;
                        short_q     <= (rem_q != '0);
                        state_q     <= S_DONE;
                    end
                end
                S_EJECT: begin
                    if (coin_sense) begin
                        rem_q      <= rem_q - coin_val;
                        eject_10_q <= 1'b0;
                        eject_5_q  <= 1'b0;
                        tmr_q      <= TMR_W'(GAP_CYC - 1);
                        state_q    <= S_GAP;
                    end else if (tmr_q == '0) begin
                        eject_10_q <= 1'b0;
                        eject_5_q  <= 1'b0;
                        state_q    <= S_SEL;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                S_GAP: begin
                    if (tmr_q == '0) state_q <= S_SEL;
                    else             tmr_q   <= tmr_q - 1'b1;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef CHANGE_AUDIT_EN
    logic [15:0] paid_total_q;
    assign paid_total = paid_total_q;

    // Running total of value actually dispensed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       paid_total_q <= '0;
        else if (sensed) paid_total_q <= paid_total_q + 16'(coin_val);
    end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with hand-computed expectations.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [7:0] req_amount;
    logic       req_ready;
    logic       load_10, load_5, coin_sense;
    logic       eject_10, eject_5, done, short;
    logic [7:0] remaining;
    logic [5:0] inv_10, inv_5;
`ifdef CHANGE_AUDIT_EN
    logic [15:0] paid_total;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    change_dispenser dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_amount (req_amount),
        .req_ready  (req_ready),
        .load_10    (load_10),
        .load_5     (load_5),
        .coin_sense (coin_sense),
        .eject_10   (eject_10),
        .eject_5    (eject_5),
        .done       (done),
        .short      (short),
        .remaining  (remaining),
        .inv_10     (inv_10),
`ifdef CHANGE_AUDIT_EN
        .inv_5      (inv_5),
        .paid_total (paid_total)
`else
        .inv_5      (inv_5)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n10, input int n5);
        int n;
        n = (n10 > n5) ? n10 : n5;
        for (int i = 0; i < n; i++) begin
            load_10 = (i < n10);
            load_5  = (i < n5);
            tick();
        end
        load_10 = 1'b0;
        load_5  = 1'b0;
    endtask

    task automatic request(input int amt);
        req_valid  = 1'b1;
        req_amount = 8'(amt);
        tick();
        req_valid  = 1'b0;
        req_amount = 8'd0;
    endtask

    task automatic pay_coin(input int coin, input string tag);
        int n = 0;
        while (!(eject_10 || eject_5) && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_e10"}, 32'(eject_10), (coin == 10) ? 1 : 0);
        chk({tag, "_e5"},  32'(eject_5),  (coin == 5)  ? 1 : 0);
        coin_sense = 1'b1;
        tick();
        coin_sense = 1'b0;
        chk({tag, "_off"}, 32'(eject_10 | eject_5), 0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic saw_done;
        reset = 1'b1; req_valid = 1'b0; req_amount = 8'd0;
        load_10 = 1'b0; load_5 = 1'b0; coin_sense = 1'b0;
        #12;
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_eject", 32'({eject_10, eject_5}), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_short", 32'(short), 0);
        chk("rst_rem",   32'(remaining), 0);
        chk("rst_inv",   32'({inv_10, inv_5}), 0);
`ifdef CHANGE_AUDIT_EN
        chk("rst_paid",  32'(paid_total), 0);
`endif
        reset = 1'b0;
        tick();

        // 25 with 3x10 and 3x5 in stock: 10, 10, 5
        load(3, 3);
        chk("t1_inv10", 32'(inv_10), 3);
        chk("t1_inv5",  32'(inv_5), 3);
        request(25);
        chk("t1_busy", 32'(req_ready), 0);
        tick();
        chk("t1_lat_e10", 32'(eject_10), 1);
        pay_coin(10, "t1_c1");
        pay_coin(10, "t1_c2");
        pay_coin(5,  "t1_c3");
        wait_done("t1");
        chk("t1_short",  32'(short), 0);
        chk("t1_rem",    32'(remaining), 0);
        chk("t1_inv10b", 32'(inv_10), 1);
        chk("t1_inv5b",  32'(inv_5), 2);
`ifdef CHANGE_AUDIT_EN
        chk("t1_paid",   32'(paid_total), 25);
`endif
        tick();
        chk("t1_pulse", 32'(done), 0);
        chk("t1_ready", 32'(req_ready), 1);

        // 20 with only 2x5: shortfall 10
        reset = 1'b1; #2; reset = 1'b0;
        tick();
        load(0, 2);
        request(20);
        pay_coin(5, "t2_c1");
        pay_coin(5, "t2_c2");
        wait_done("t2");
        chk("t2_short", 32'(short), 1);
        chk("t2_rem",   32'(remaining), 10);
        chk("t2_inv5",  32'(inv_5), 0);
        tick();

        // jammed 10 hopper: timeout after 16 cycles, then paid in 5s
        load(2, 3);
        request(10);
        tick();
        n = 0;
        while (eject_10 && n < 40) begin
            tick();
            n++;
        end
        chk("t3_jam_cycles", n, 16);
        chk("t3_inv10", 32'(inv_10), 0);
        pay_coin(5, "t3_c1");
        pay_coin(5, "t3_c2");
        wait_done("t3");
        chk("t3_short", 32'(short), 0);
        chk("t3_inv5",  32'(inv_5), 1);
        tick();

        // zero request finishes at T+2 without ejecting
        request(0);
        tick();
        chk("t4_done0",  32'(done), 1);
        chk("t4_eject0", 32'({eject_10, eject_5}), 0);
        chk("t4_short0", 32'(short), 0);
        tick();

        // 7 with one 5 in stock: residue 2
        request(7);
        pay_coin(5, "t4_c7");
        wait_done("t4");
        chk("t4_rem7",   32'(remaining), 2);
        chk("t4_short7", 32'(short), 1);
        chk("t4_inv5",   32'(inv_5), 0);
        tick();

        // load and dispense of a 10 in the same cycle cancel
        load(1, 0);
        request(10);
        tick();
        chk("t5_e10", 32'(eject_10), 1);
        coin_sense = 1'b1;
        load_10    = 1'b1;
        tick();
        coin_sense = 1'b0;
        load_10    = 1'b0;
        chk("t5_inv10", 32'(inv_10), 1);
        wait_done("t5");
        chk("t5_rem", 32'(remaining), 0);
        tick();

        // inventory saturation
        load(0, 70);
        chk("t5_sat5", 32'(inv_5), 63);

        // request ignored while busy, then reset during eject
        request(10);
        req_valid  = 1'b1;
        req_amount = 8'd5;
        tick();
        req_valid  = 1'b0;
        chk("t6_e10", 32'(eject_10), 1);
        reset = 1'b1;
        #1;
        chk("t6_eject",  32'({eject_10, eject_5}), 0);
        chk("t6_inv",    32'({inv_10, inv_5}), 0);
        chk("t6_ready",  32'(req_ready), 1);
        chk("t6_done",   32'(done), 0);
`ifdef CHANGE_AUDIT_EN
        chk("t6_paid",   32'(paid_total), 0);
`endif
        #3;
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || eject_10 || eject_5) saw_done = 1'b1;
        end
        chk("t6_quiet", 32'(saw_done), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
